// File: rtl/dec_gray2bin_pipe.sv
// Streaming Gray-to-binary decoder with valid/ready pipeline and a +0/+1 step checker.
// The prefix XOR is split MSB-first across STAGES registers; err_cnt saturates.
module dec_gray2bin_pipe #(
    parameter int WIDTH  = 10,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_gray,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_bin,
    output logic             out_step_err,
    output logic [15:0]      err_cnt
);

    localparam int SLICE = (WIDTH + STAGES - 1) / STAGES;

    // Lowest bit index that is fully decoded once stage s (1-based) has been applied.
    function automatic int slice_lo(input int s);
        int lo;
        lo = WIDTH - s * SLICE;
        if (lo < 0) lo = 0;
        return lo;
    endfunction

    // Decode bits [top-1:lo]; bits at/above top are already binary, bits below lo stay Gray.
    function automatic logic [WIDTH-1:0] dec_slice(input logic [WIDTH-1:0] w,
                                                   input int lo, input int top);
        logic [WIDTH-1:0] r;
        r = w;
        for (int i = WIDTH - 2; i >= 0; i--) begin
            if (i >= lo && i < top) r[i] = r[i+1] ^ w[i];
        end
        return r;
    endfunction

    logic [WIDTH-1:0] stg_q [STAGES];
    logic [WIDTH-1:0] stg_d [STAGES];
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    logic [WIDTH-1:0] prev_bin_q;
    logic [WIDTH-1:0] prev_bin_d;
    logic             have_prev_q;
    logic             have_prev_d;
    logic [15:0]      err_cnt_q;
    logic [15:0]      err_cnt_d;
    logic             en;
    logic [WIDTH-1:0] step_diff;

    assign out_bin   = stg_q[STAGES-1];
    assign out_valid = vld_q[STAGES-1];
    assign en        = !out_valid | out_ready;
    assign in_ready  = en;
    assign err_cnt   = err_cnt_q;

    // Subtraction wraps naturally at WIDTH bits, so max->0 yields a step of one.
    assign step_diff    = out_bin - prev_bin_q;
    assign out_step_err = out_valid & have_prev_q & (step_diff > WIDTH'(1));

    always_comb begin
        stg_d = stg_q;
        vld_d = vld_q;
        if (en) begin
            stg_d[0] = dec_slice(in_gray, slice_lo(1), WIDTH);
            vld_d[0] = in_valid;
            for (int s = 1; s < STAGES; s++) begin
                stg_d[s] = dec_slice(stg_q[s-1], slice_lo(s + 1), slice_lo(s));
                vld_d[s] = vld_q[s-1];
            end
        end
    end

    always_comb begin
        prev_bin_d  = prev_bin_q;
        have_prev_d = have_prev_q;
        err_cnt_d   = err_cnt_q;
        if (out_valid && out_ready) begin
            prev_bin_d  = out_bin;
            have_prev_d = 1'b1;
            if (out_step_err && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) stg_q[s] <= '0;
            vld_q       <= '0;
            prev_bin_q  <= '0;
            have_prev_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            stg_q       <= stg_d;
            vld_q       <= vld_d;
            prev_bin_q  <= prev_bin_d;
            have_prev_q <= have_prev_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_dec_gray2bin_pipe.sv
// Bench for dec_gray2bin_pipe: directed cases on a STAGES=2 instance, then random
// valid/ready traffic on STAGES=1,2,5,10 instances against a scoreboard model.
module tb_dec_gray2bin_pipe;

    localparam int W  = 10;
    localparam int NI = 4;
    localparam int D  = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          in_valid_a     [NI];
    logic          in_ready_a     [NI];
    logic [W-1:0]  in_gray_a      [NI];
    logic          out_valid_a    [NI];
    logic          out_ready_a    [NI];
    logic [W-1:0]  out_bin_a      [NI];
    logic          out_step_err_a [NI];
    logic [15:0]   err_cnt_a      [NI];

    for (genvar k = 0; k < NI; k++) begin : g_dut
        localparam int STG = (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 5 : 10;
        dec_gray2bin_pipe #(.WIDTH(W), .STAGES(STG)) u_dut (
            .clk          (clk),
            .rst          (rst),
            .in_valid     (in_valid_a[k]),
            .in_ready     (in_ready_a[k]),
            .in_gray      (in_gray_a[k]),
            .out_valid    (out_valid_a[k]),
            .out_ready    (out_ready_a[k]),
            .out_bin      (out_bin_a[k]),
            .out_step_err (out_step_err_a[k]),
            .err_cnt      (err_cnt_a[k])
        );
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: binary -> Gray encoder, and its inverse via a lookup table.
    function automatic logic [W-1:0] gray(input int b);
        logic [W-1:0] v;
        v = W'(b % 1024);
        return v ^ (v >> 1);
    endfunction

    int inv_tab [1024];

    logic [W-1:0] sb_mem [NI][64];
    int  sb_wr   [NI];
    int  sb_rd   [NI];
    int  m_prev  [NI];
    bit  m_have  [NI];
    int  m_cnt   [NI];
    int  n_out   [NI];
    int  cur     [NI];
    int  last_wr [NI];

    task automatic step();
        int exp_bin;
        int d;
        bit exp_err;
        #1;
        for (int k = 0; k < NI; k++) begin
            if (rst) begin
                sb_wr[k]  = 0;
                sb_rd[k]  = 0;
                m_prev[k] = 0;
                m_have[k] = 1'b0;
                m_cnt[k]  = 0;
            end else begin
                if (out_valid_a[k] && out_ready_a[k]) begin
                    if (sb_wr[k] == sb_rd[k]) begin
                        check_eq($sformatf("u%0d unexpected out_valid", k), 32'(out_valid_a[k]), 32'd0);
                    end else begin
                        exp_bin = int'(sb_mem[k][sb_rd[k] % 64]);
                        sb_rd[k]++;
                        d = (exp_bin - m_prev[k] + 1024) % 1024;
                        exp_err = m_have[k] && (d > 1);
                        check_eq($sformatf("u%0d out_bin", k), 32'(out_bin_a[k]), 32'(exp_bin));
                        check_eq($sformatf("u%0d out_step_err", k), 32'(out_step_err_a[k]), 32'(exp_err));
                        check_eq($sformatf("u%0d err_cnt", k), 32'(err_cnt_a[k]), 32'(m_cnt[k]));
                        if (exp_err && m_cnt[k] < 65535) m_cnt[k]++;
                        m_prev[k] = exp_bin;
                        m_have[k] = 1'b1;
                        n_out[k]++;
                    end
                end else if (!out_valid_a[k]) begin
                    check_eq($sformatf("u%0d step_err idle", k), 32'(out_step_err_a[k]), 32'd0);
                end
                if (in_valid_a[k] && in_ready_a[k]) begin
                    sb_mem[k][sb_wr[k] % 64] = W'(inv_tab[in_gray_a[k]]);
                    sb_wr[k]++;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < NI; k++) begin
            in_valid_a[k]  = 1'b0;
            out_ready_a[k] = 1'b1;
        end
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    int n0;

    initial begin
        rst = 1'b1;
        for (int k = 0; k < NI; k++) begin
            in_valid_a[k]  = 1'b0;
            in_gray_a[k]   = '0;
            out_ready_a[k] = 1'b1;
            sb_wr[k] = 0; sb_rd[k] = 0; m_prev[k] = 0; m_have[k] = 1'b0;
            m_cnt[k] = 0; n_out[k] = 0; cur[k] = 0; last_wr[k] = 0;
        end
        for (int b = 0; b < 1024; b++) inv_tab[gray(b)] = b;
        @(negedge clk);

        // Reset state
        out_ready_a[D] = 1'b0;
        step();
        step();
        check_eq("reset out_valid", 32'(out_valid_a[D]), 32'd0);
        check_eq("reset out_bin", 32'(out_bin_a[D]), 32'd0);
        check_eq("reset err_cnt", 32'(err_cnt_a[D]), 32'd0);
        check_eq("reset in_ready", 32'(in_ready_a[D]), 32'd1);
        rst = 1'b0;
        out_ready_a[D] = 1'b1;

        // Single words and latency
        in_valid_a[D] = 1'b1;
        in_gray_a[D]  = 10'h200;
        step();
        in_valid_a[D] = 1'b0;
        check_eq("latency early out_valid", 32'(out_valid_a[D]), 32'd0);
        step();
        check_eq("latency out_valid", 32'(out_valid_a[D]), 32'd1);
        check_eq("single 0x200", 32'(out_bin_a[D]), 32'h3FF);
        in_valid_a[D] = 1'b1;
        in_gray_a[D]  = 10'h0C5;
        step();
        in_valid_a[D] = 1'b0;
        step();
        check_eq("single 0x0C5 valid", 32'(out_valid_a[D]), 32'd1);
        check_eq("single 0x0C5", 32'(out_bin_a[D]), 32'h086);
        drain(4);

        // Full sweep with wrap, one word per cycle
        do_reset();
        n0 = n_out[D];
        for (int i = 0; i <= 1024; i++) begin
            in_valid_a[D] = 1'b1;
            in_gray_a[D]  = gray(i);
            step();
        end
        in_valid_a[D] = 1'b0;
        step();
        step();
        check_eq("sweep throughput", 32'(n_out[D] - n0), 32'd1025);
        drain(3);
        check_eq("sweep err_cnt", 32'(err_cnt_a[D]), 32'd0);

        // Backpressure
        do_reset();
        out_ready_a[D] = 1'b0;
        in_valid_a[D]  = 1'b1;
        in_gray_a[D]   = gray(10);
        step();
        in_gray_a[D]   = gray(11);
        step();
        in_gray_a[D]   = gray(12);
        check_eq("bp in_ready", 32'(in_ready_a[D]), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("bp stall in_ready", 32'(in_ready_a[D]), 32'd0);
            check_eq("bp stall out_bin", 32'(out_bin_a[D]), 32'd10);
            check_eq("bp stall out_valid", 32'(out_valid_a[D]), 32'd1);
        end
        n0 = n_out[D];
        out_ready_a[D] = 1'b1;
        step();
        drain(5);
        check_eq("bp words out", 32'(n_out[D] - n0), 32'd3);
        check_eq("bp scoreboard empty", 32'(sb_wr[D] - sb_rd[D]), 32'd0);
        check_eq("bp err_cnt", 32'(err_cnt_a[D]), 32'd0);

        // Step errors and saturation
        do_reset();
        in_valid_a[D] = 1'b1;
        in_gray_a[D]  = gray(5);
        step();
        in_gray_a[D]  = gray(9);
        step();
        in_valid_a[D] = 1'b0;
        step();
        check_eq("jump out_bin", 32'(out_bin_a[D]), 32'd9);
        check_eq("jump out_step_err", 32'(out_step_err_a[D]), 32'd1);
        step();
        check_eq("jump err_cnt", 32'(err_cnt_a[D]), 32'd1);
        drain(3);
        in_valid_a[D] = 1'b1;
        in_gray_a[D]  = gray(9);
        step();
        in_valid_a[D] = 1'b0;
        step();
        check_eq("repeat out_bin", 32'(out_bin_a[D]), 32'd9);
        check_eq("repeat out_step_err", 32'(out_step_err_a[D]), 32'd0);
        drain(3);
        check_eq("repeat err_cnt", 32'(err_cnt_a[D]), 32'd1);
        for (int i = 0; i < 70000; i++) begin
            in_valid_a[D] = 1'b1;
            in_gray_a[D]  = gray((i % 2 == 1) ? 512 : 0);
            step();
        end
        drain(4);
        check_eq("saturated err_cnt", 32'(err_cnt_a[D]), 32'hFFFF);

        // Reset during a stall
        do_reset();
        in_valid_a[D] = 1'b1;
        in_gray_a[D]  = gray(100);
        step();
        drain(3);
        out_ready_a[D] = 1'b0;
        in_valid_a[D]  = 1'b1;
        in_gray_a[D]   = gray(101);
        step();
        in_gray_a[D]   = gray(102);
        step();
        in_valid_a[D]  = 1'b0;
        step();
        check_eq("midrst stalled out_valid", 32'(out_valid_a[D]), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("midrst out_valid", 32'(out_valid_a[D]), 32'd0);
        check_eq("midrst in_ready", 32'(in_ready_a[D]), 32'd1);
        out_ready_a[D] = 1'b1;
        in_valid_a[D]  = 1'b1;
        in_gray_a[D]   = gray(700);
        step();
        in_valid_a[D]  = 1'b0;
        step();
        check_eq("midrst out_bin", 32'(out_bin_a[D]), 32'd700);
        check_eq("midrst out_step_err", 32'(out_step_err_a[D]), 32'd0);
        step();
        check_eq("midrst err_cnt", 32'(err_cnt_a[D]), 32'd0);
        drain(3);

        // Random valid/ready traffic on every pipeline depth
        do_reset();
        for (int k = 0; k < NI; k++) last_wr[k] = sb_wr[k];
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < NI; k++) begin
                if (!in_valid_a[k] || sb_wr[k] != last_wr[k]) begin
                    int r;
                    r = int'($urandom_range(0, 99));
                    if (r < 70)      cur[k] = (cur[k] + 1) % 1024;
                    else if (r >= 85) cur[k] = int'($urandom_range(0, 1023));
                    in_valid_a[k] = ($urandom_range(0, 99) < 65);
                    in_gray_a[k]  = gray(cur[k]);
                end
                last_wr[k]     = sb_wr[k];
                out_ready_a[k] = ($urandom_range(0, 99) < 70);
            end
            step();
        end
        drain(15);
        for (int k = 0; k < NI; k++)
            check_eq($sformatf("u%0d random drained", k), 32'(sb_wr[k] - sb_rd[k]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
